// File: rtl/wb_arbiter_if.sv
// Bundle of the write-back arbiter's pipeline-facing signals: ALU results, long-unit results,
// long-op issue tracking, decode hazard queries and the registered register-file write port.
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_hold;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              rs_busy;
  logic              rt_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic              proto_err;

  // The arbiter itself.
  modport slave (
    input  alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs, rt,
    output alu_hold, lu_ready, rs_busy, rt_busy, rf_we, rf_rd, rf_wdata, proto_err
  );

  // The pipeline stages driving and observing the arbiter.
  modport master (
    output alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
           iss_valid, iss_rd, rs, rt,
    input  alu_hold, lu_ready, rs_busy, rt_busy, rf_we, rf_rd, rf_wdata, proto_err
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results with buffered long-latency results into one
// registered register-file write per cycle, and keeps the pending-write scoreboard for decode.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ZERO_RD    = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [SW-1:0]     starve_r;
  logic [NREG-1:0]   pending_r;
  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_rd_r;
  logic [DATA_W-1:0] rf_wdata_r;
  logic              src_fifo_r;
  logic              proto_err_r;

  logic              alu_hold_s;
  logic              lu_ready_s;
  logic              fifo_empty_s;
  logic              alu_take_s;
  logic              pop_s;
  logic              push_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [SW-1:0]     starve_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [NREG-1:0]   clr_mask_s;
  logic [NREG-1:0]   set_mask_s;
  logic [NREG-1:0]   pending_nxt_s;

  assign fifo_empty_s = (count_r == '0);
  assign lu_ready_s   = (count_r != FULL_CNT);
  assign alu_hold_s   = (starve_r == STARVE_LIM);
  assign push_s       = bus.lu_valid && lu_ready_s && (bus.lu_rd != ZERO_RD);

  // Pick this cycle's write source: a real ALU result wins unless held, else the FIFO head.
  always_comb begin
    alu_take_s = 1'b0;
    pop_s      = 1'b0;
    sel_rd_s   = rf_rd_r;
    sel_data_s = rf_wdata_r;
    if (!alu_hold_s && bus.alu_valid && (bus.alu_rd != ZERO_RD)) begin
      alu_take_s = 1'b1;
      sel_rd_s   = bus.alu_rd;
      sel_data_s = bus.alu_data;
    end else if (!fifo_empty_s) begin
      pop_s      = 1'b1;
      sel_rd_s   = fifo_mem_r[rd_ptr_r].rd;
      sel_data_s = fifo_mem_r[rd_ptr_r].data;
    end else begin
      pop_s      = 1'b0;
    end
  end

  // Starvation counter, FIFO occupancy and scoreboard next state.
  always_comb begin
    starve_nxt_s = starve_r;
    count_nxt_s  = count_r;
    if (pop_s || fifo_empty_s) begin
      starve_nxt_s = '0;
    end else if (alu_take_s && (starve_r != STARVE_LIM)) begin
      starve_nxt_s = starve_r + SW'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    // Clear for the FIFO write committing now, set for a new issue; set applied last so it wins.
    clr_mask_s    = (rf_we_r && src_fifo_r) ? (NREG'(1'b1) << rf_rd_r) : '0;
    set_mask_s    = bus.iss_valid ? (NREG'(1'b1) << bus.iss_rd) : '0;
    pending_nxt_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~NREG'(1'b1);
  end

  // Control state, scoreboard and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      starve_r    <= '0;
      pending_r   <= '0;
      rf_we_r     <= 1'b0;
      rf_rd_r     <= '0;
      rf_wdata_r  <= '0;
      src_fifo_r  <= 1'b0;
      proto_err_r <= 1'b0;
    end else begin
      wr_ptr_r    <= push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
      rd_ptr_r    <= pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
      count_r     <= count_nxt_s;
      starve_r    <= starve_nxt_s;
      pending_r   <= pending_nxt_s;
      rf_we_r     <= alu_take_s || pop_s;
      rf_rd_r     <= sel_rd_s;
      rf_wdata_r  <= sel_data_s;
      src_fifo_r  <= pop_s;
      proto_err_r <= proto_err_r || (bus.alu_valid && alu_hold_s);
    end
  end

  // Long-unit result storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= '0;
      end
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= '{rd: bus.lu_rd, data: bus.lu_data};
    end
  end

  assign bus.alu_hold  = alu_hold_s;
  assign bus.lu_ready  = lu_ready_s;
  assign bus.rs_busy   = pending_r[bus.rs];
  assign bus.rt_busy   = pending_r[bus.rt];
  assign bus.rf_we     = rf_we_r;
  assign bus.rf_rd     = rf_rd_r;
  assign bus.rf_wdata  = rf_wdata_r;
  assign bus.proto_err = proto_err_r;
endmodule
